// File: rtl/wb_audio_rx_pkg.sv
// Shared constants for the serial-audio receiver: register map, bit positions
// and sample geometry.
package wb_audio_rx_pkg;

  localparam int unsigned SAMPLE_BITS = 16;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int unsigned ST_EMPTY   = 0;
  localparam int unsigned ST_FULL    = 1;
  localparam int unsigned ST_OVF     = 2;
  localparam int unsigned ST_FERR    = 3;
  localparam int unsigned ST_EN      = 4;
  localparam int unsigned ST_LVL_LSB = 8;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_CLR   = 1;
  localparam int unsigned CTRL_FLUSH = 2;

  typedef logic [SAMPLE_BITS-1:0] sample_t;

  function automatic logic [31:0] pack_pair(input sample_t l, input sample_t r);
    return {l, r};
  endfunction

endpackage

// File: rtl/wb_audio_rx_if.sv
// Wishbone slave bus bundle for the audio receiver region.
interface wb_audio_rx_if;
  logic [31:0] slave_dat_i;
  logic [31:0] slave_dat_o;
  logic [13:0] adr_i;
  logic        cyc_i;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic        ack_o;
  logic        err_o;

  modport slave (
    input  slave_dat_i, adr_i, cyc_i, stb_i, we_i, sel_i,
    output slave_dat_o, ack_o, err_o
  );

  modport master (
    output slave_dat_i, adr_i, cyc_i, stb_i, we_i, sel_i,
    input  slave_dat_o, ack_o, err_o
  );
endinterface

// File: rtl/audio_rx_fifo.sv
// Synchronous 32-bit FIFO with flush; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module audio_rx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_audio_rx.sv
// Serial-audio capture: deserializes left-justified 16-bit stereo into {L,R}
// pairs buffered in a FIFO that the CPU drains over Wishbone.
module wb_audio_rx
  import wb_audio_rx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned IRQ_THRESH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         bck_i,
  input  logic         lrclk_i,
  input  logic         data_i,
  wb_audio_rx_if.slave wb,
  output logic         irq_o
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW = $clog2(SAMPLE_BITS) + 1;

  logic [1:0]    bck_sync, lr_sync, dat_sync;
  logic          bck_d, bck_rise, lr_s, dat_s;
  logic          lr_prev, enable, left_valid, overflow, frame_err;
  logic [CW-1:0] cnt;
  sample_t       shreg, left_word;
  logic          close, store_left, push_pair, bad_word;
  logic          req, pop, ctrl_wr, clr_flags, flush, push;
  logic          full, empty, ack;
  logic [LW-1:0] level;
  logic [31:0]   head, dat_o, status;
  logic          unused_bits;

  assign lr_s     = lr_sync[1];
  assign dat_s    = dat_sync[1];
  assign bck_rise = bck_sync[1] & ~bck_d;

  assign req       = wb.cyc_i & wb.stb_i & ~ack;
  assign pop       = req & ~wb.we_i & (wb.adr_i[1:0] == REG_DATA) & ~empty;
  assign ctrl_wr   = req & wb.we_i & (wb.adr_i[1:0] == REG_CTRL) & wb.sel_i[0];
  assign clr_flags = ctrl_wr & wb.slave_dat_i[CTRL_CLR];
  assign flush     = ctrl_wr & wb.slave_dat_i[CTRL_FLUSH];

  assign wb.ack_o       = ack;
  assign wb.slave_dat_o = dat_o;
  assign wb.err_o       = 1'b0;
  assign unused_bits    = ^{wb.adr_i[13:2], wb.slave_dat_i[31:3], wb.sel_i[3:1]};

  // A zero count marks "not yet aligned": bits are only shifted after a word
  // boundary, so the word in flight at enable closes silently with count 0.
  always_comb begin
    close      = bck_rise & enable & (lr_s != lr_prev);
    store_left = close & (cnt == CW'(SAMPLE_BITS)) & ~lr_prev;
    push_pair  = close & (cnt == CW'(SAMPLE_BITS)) & lr_prev & left_valid;
    bad_word   = close & (cnt != '0) & ~store_left & ~push_pair;
    push       = push_pair & ~flush;
  end

  always_comb begin
    status                   = '0;
    status[ST_EMPTY]         = empty;
    status[ST_FULL]          = full;
    status[ST_OVF]           = overflow;
    status[ST_FERR]          = frame_err;
    status[ST_EN]            = enable;
    status[ST_LVL_LSB +: 8]  = 8'(level);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bck_sync <= '0;
      lr_sync  <= '0;
      dat_sync <= '0;
      bck_d    <= 1'b0;
    end else begin
      bck_sync <= {bck_sync[0], bck_i};
      lr_sync  <= {lr_sync[0], lrclk_i};
      dat_sync <= {dat_sync[0], data_i};
      bck_d    <= bck_sync[1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lr_prev    <= 1'b0;
      cnt        <= '0;
      shreg      <= '0;
      left_word  <= '0;
      left_valid <= 1'b0;
    end else begin
      if (bck_rise) lr_prev <= lr_s;
      if (!enable) begin
        cnt <= '0;
      end else if (close) begin
        shreg <= {{(SAMPLE_BITS-1){1'b0}}, dat_s};
        cnt   <= CW'(1);
      end else if (bck_rise && cnt != '0 && cnt < CW'(SAMPLE_BITS)) begin
        shreg <= {shreg[SAMPLE_BITS-2:0], dat_s};
        cnt   <= cnt + CW'(1);
      end
      if (store_left) left_word <= shreg;
      if (flush || !enable)  left_valid <= 1'b0;
      else if (store_left)   left_valid <= 1'b1;
      else if (close)        left_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enable    <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      ack       <= 1'b0;
      dat_o     <= '0;
      irq_o     <= 1'b0;
    end else begin
      if (ctrl_wr) enable <= wb.slave_dat_i[CTRL_EN];
      overflow  <= ~clr_flags & (overflow | (push & full & ~pop));
      frame_err <= ~clr_flags & (frame_err | bad_word);
      ack       <= req;
      if (req && !wb.we_i) begin
        case (wb.adr_i[1:0])
          REG_DATA:   dat_o <= empty ? '0 : head;
          REG_STATUS: dat_o <= status;
          REG_CTRL:   dat_o <= {31'b0, enable};
          default:    dat_o <= '0;
        endcase
      end
      irq_o <= enable & (level >= LW'(IRQ_THRESH));
    end
  end

  audio_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (pack_pair(left_word, shreg)),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule
